id_imm_sequencer: RTL
=====================

// Module: id_imm_sequencer
// PURPOSE
//  Decode-stage front end for the RV32I pipeline.
//  - Accepts fetched instructions over a valid/ready handshake.
//  - Classifies the opcode into the Imm_op encoding and drives the existing Imm_Gen datapath.
//  - Registers instr/pc/immediate into a 2-entry (main + skid) output buffer for the EX stage.
//  - Supports pipeline flush and counts back-pressure (stall) cycles.
// PARAMETERS
//  PC_W         32  width of in_pc/out_pc
//  STALL_CNT_W  16  width of saturating stall counter
// PORTS
//  clk          in   1            single clock; all state on posedge
//  rst_n        in   1            asynchronous, active-low reset
//  flush        in   1            synchronous pipeline kill (branch mispredict/trap)
//  in_valid     in   1            IF has an instruction
//  in_ready     out  1            ID can accept (registered)
//  in_instr     in   32           instruction word
//  in_pc        in   PC_W         PC of in_instr
//  out_valid    out  1            EX-side entry valid
//  out_ready    in   1            EX accepts entry
//  out_instr    out  32           registered instruction
//  out_pc       out  PC_W         registered PC
//  out_imm      out  32           registered sign-extended immediate
//  out_imm_op   out  3            registered Imm_op used
//  out_illegal  out  1            opcode not in RV32I base set
//  stall_cnt    out  STALL_CNT_W  cycles with out_valid & !out_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): state=EMPTY, in_ready=1, all out_* = 0, stall_cnt=0.
//  Opcode -> Imm_op (combinational, on in_instr[6:0]):
//    0000011, 0010011, 1100111, 0001111, 1110011 -> 3'b001 (I)
//    0100011 -> 3'b010 (S); 1100011 -> 3'b011 (B)
//    0110111, 0010111 -> 3'b100 (U); 1101111 -> 3'b101 (J)
//    0110011 -> 3'b000 (imm=0, legal)
//    any other -> 3'b000, illegal=1; still passed downstream, never dropped.
//  Immediate is computed from in_instr before buffering; in->out latency = 1 cycle.
//  in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  FSM (out_valid = state!=EMPTY; in_ready registered, = next state != FULL):
//    EMPTY: in_fire -> BUSY (load main)
//    BUSY:  in_fire & out_ready  -> BUSY (main <= new)
//           in_fire & !out_ready -> FULL (skid <= new)
//           !in_fire & out_ready -> EMPTY
//    FULL:  out_ready -> BUSY (main <= skid); in_ready=0, so no input accepted
//  Ordering strictly FIFO; no duplication or loss except by flush.
//  out_* stable while out_valid & !out_ready (AXI-style hold); in_valid may drop any time.
//  flush (highest priority): next state EMPTY, main+skid invalidated, same-cycle in_fire discarded,
//    in_ready=1 next cycle. Data regs need not clear; out_valid must.
//  stall_cnt: +1 per cycle out_valid & !out_ready; saturates at all-ones; unaffected by flush.
//  rst_n asserted mid-transfer: immediate return to reset values; no partial entries survive.
// STRUCTURE
//  Shared pkg (rv32i_pkg): OPC_* 7-bit opcode constants; IMM_NONE/I/S/B/U/J 3-bit codes
//    (000/001/010/011/100/101); FSM state codes EMPTY/BUSY/FULL.
//  Sub-module imm_op_decode: combinational opcode -> {imm_op, illegal}.
//  Imm_Gen instantiated unchanged (instruction=in_instr, Imm_op=decoded op).
//  Top: FSM, main/skid registers, stall counter.
// TESTING
//  1 addi 0xFFF00093, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, op=001, illegal=0.
//  2 sw 0x00112623 -> imm=0x0000000C, op=010; beq 0xFE000EE3 -> imm=0xFFFFFFFC, op=011.
//  3 lui 0x123452B7 -> imm=0x12345000, op=100; jal 0x001000EF -> imm=0x00000800, op=101;
//    add 0x002081B3 -> imm=0, op=000; opcode 0x7F -> illegal=1, op=000.
//  4 out_ready=0, push A,B -> FULL, in_ready=0, C held off, stall_cnt increments;
//    release -> A,B,C emitted in order, one per cycle.
//  5 flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    flushed-cycle input never appears.
//  6 assert rst_n=0 mid-stream (async, between edges) -> outputs zero immediately;
//    stall_cnt=0; saturation check with STALL_CNT_W=4 holds 0xF.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: base opcodes, immediate-format codes,
// decode-stage buffer state codes and the buffered entry layout.
package rv32i_pkg;

  // Base RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  // Imm_op encoding understood by Imm_Gen
  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  // Output buffer occupancy: no entry, main only, main + skid
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BUSY  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  // One decoded entry (PC is carried separately because its width is a parameter)
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  imm_op;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/Imm_Gen.sv
// Immediate generator: assembles the sign-extended 32-bit immediate of the
// format selected by Imm_op. The opcode field is not needed here.
module Imm_Gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [2:0]  Imm_op,
  output logic [31:0] imm_out
);

  logic unused_opcode;
  assign unused_opcode = ^instruction[6:0];

  // Format-dependent bit gathering with sign extension from instr[31]
  always_comb begin
    imm_out = 32'h0;
    case (Imm_op)
      IMM_I: imm_out = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S: imm_out = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm_out = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: imm_out = {instruction[31:12], 12'h000};
      IMM_J: imm_out = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      default: imm_out = 32'h0;
    endcase
  end

endmodule

// File: rtl/imm_op_decode.sv
// Combinational opcode classifier: maps instr[6:0] onto the Imm_op code and
// flags opcodes outside the RV32I base set (they still flow downstream).
module imm_op_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_op,
  output logic       illegal
);

  // Opcode lookup; unknown opcodes get no immediate and the illegal flag
  always_comb begin
    imm_op  = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:  imm_op = IMM_I;
      OPC_STORE:                 imm_op = IMM_S;
      OPC_BRANCH:                imm_op = IMM_B;
      OPC_LUI, OPC_AUIPC:        imm_op = IMM_U;
      OPC_JAL:                   imm_op = IMM_J;
      OPC_OP:                    imm_op = IMM_NONE;
      default:                   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_imm_sequencer.sv
// Decode-stage front end: decodes the immediate of each accepted instruction
// and holds it in a main + skid output buffer toward EX, with flush and a
// saturating back-pressure counter.
module id_imm_sequencer
  import rv32i_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [31:0]            out_imm,
  output logic [2:0]             out_imm_op,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [2:0]  dec_imm_op;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  entry_t      new_entry;

  logic [1:0]             state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  entry_t                 main_q, main_d, skid_q, skid_d;
  logic [PC_W-1:0]        main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic in_fire;

  imm_op_decode u_decode (
    .opcode  (in_instr[6:0]),
    .imm_op  (dec_imm_op),
    .illegal (dec_illegal)
  );

  Imm_Gen u_imm_gen (
    .instruction (in_instr),
    .Imm_op      (dec_imm_op),
    .imm_out     (dec_imm)
  );

  assign new_entry = '{instr: in_instr, imm: dec_imm, imm_op: dec_imm_op, illegal: dec_illegal};
  assign in_fire   = in_valid & in_ready_q;

  // Buffer FSM, data steering, registered ready and stall counting
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    main_pc_d   = main_pc_q;
    skid_d      = skid_q;
    skid_pc_d   = skid_pc_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = BUSY;
          main_d    = new_entry;
          main_pc_d = in_pc;
        end
      end
      BUSY: begin
        if (in_fire && out_ready) begin
          main_d    = new_entry;
          main_pc_d = in_pc;
        end else if (in_fire) begin
          state_d   = FULL;
          skid_d    = new_entry;
          skid_pc_d = in_pc;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so no new entry can arrive this cycle
        if (out_ready) begin
          state_d   = BUSY;
          main_d    = skid_q;
          main_pc_d = skid_pc_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush only has to drop occupancy; stale data in main/skid is never exposed
    if (flush) begin
      state_d = EMPTY;
    end

    in_ready_d = (state_d != FULL);

    if ((state_q != EMPTY) && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, buffer and counter registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      main_pc_q   <= '0;
      skid_q      <= '0;
      skid_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_q      <= main_d;
      main_pc_q   <= main_pc_d;
      skid_q      <= skid_d;
      skid_pc_q   <= skid_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_instr   = main_q.instr;
  assign out_pc      = main_pc_q;
  assign out_imm     = main_q.imm;
  assign out_imm_op  = main_q.imm_op;
  assign out_illegal = main_q.illegal;
  assign stall_cnt   = stall_cnt_q;

endmodule
